// File: rtl/renkon_pool_maxn_if.sv
// Stream bus for the max-pooling block: element input, pooled result output.
interface renkon_pool_maxn_if #(
  parameter int DWIDTH   = 16,
  parameter int CHANNELS = 4
);
  logic                         clear;
  logic                         relu_en;
  logic                         in_valid;
  logic [CHANNELS*DWIDTH-1:0]   in_data;
  logic                         out_valid;
  logic [CHANNELS*DWIDTH-1:0]   out_data;
  logic                         busy;

  modport master (
    output clear, relu_en, in_valid, in_data,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  clear, relu_en, in_valid, in_data,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/renkon_pool_maxn.sv
// KSIZE x KSIZE signed max pooling over CHANNELS lanes with a shared
// window counter, optional ReLU clamp and single-cycle result pulse.

// One lane: running signed maximum plus the held pooled result.
module renkon_pool_maxn_lane #(
  parameter int DWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     first,
  input  logic                     upd,
  input  logic                     last,
  input  logic                     relu,
  input  logic signed [DWIDTH-1:0] din,
  output logic signed [DWIDTH-1:0] dout
);
  logic signed [DWIDTH-1:0] acc;
  logic signed [DWIDTH-1:0] mx;

  // max including the element arriving this cycle; used for both update and result
  assign mx = (din > acc) ? din : acc;

  // accumulate the window maximum; capture (clamped) result on the last element
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      dout <= '0;
    end else begin
      if (first)    acc <= din;
      else if (upd) acc <= mx;
      if (last)     dout <= (relu && mx[DWIDTH-1]) ? '0 : mx;
    end
  end
endmodule

module renkon_pool_maxn #(
  parameter int DWIDTH   = 16,
  parameter int KSIZE    = 3,
  parameter int CHANNELS = 4
) (
  input  logic               clk,
  input  logic               rst,
  renkon_pool_maxn_if.slave  bus
);
  localparam int KK = KSIZE * KSIZE;
  localparam int CW = $clog2(KK);
  localparam logic [CW-1:0] LASTC = CW'(KK - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                            state;
  logic [CW-1:0]                     cnt;
  logic                              relu_q;
  logic                              vld_q;
  logic                              accept, first, upd, last;
  logic [CHANNELS-1:0][DWIDTH-1:0]   res;

  // clear wins over in_valid: a cleared element never reaches the lanes
  assign accept = bus.in_valid & ~bus.clear;
  assign first  = accept & (state == IDLE);
  assign upd    = accept & (state == ACC);
  assign last   = upd & (cnt == LASTC);

  // window control: state, element count, relu latch and result pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      relu_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= last;
      if (bus.clear) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (bus.in_valid) begin
        if (state == IDLE) begin
          state  <= ACC;
          cnt    <= CW'(1);
          relu_q <= bus.relu_en;
        end else if (last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    renkon_pool_maxn_lane #(.DWIDTH(DWIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .first(first),
      .upd  (upd),
      .last (last),
      .relu (relu_q),
      .din  (bus.in_data[c*DWIDTH +: DWIDTH]),
      .dout (res[c])
    );
  end

  assign bus.out_data  = res;
  assign bus.out_valid = vld_q;
  assign bus.busy      = (state == ACC);
endmodule

// File: tb/tb_renkon_pool_maxn.sv
// Randomized self-checking bench: window maxima predicted from collected
// elements, compared against observed out_valid pulses.
module tb_renkon_pool_maxn;
  localparam int DW = 16;
  localparam int CH = 4;
  localparam int KK = 9;
  localparam int W  = CH * DW;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  renkon_pool_maxn_if #(.DWIDTH(DW), .CHANNELS(CH)) ifa ();
  renkon_pool_maxn_if #(.DWIDTH(DW), .CHANNELS(CH)) ifb ();

  renkon_pool_maxn #(.DWIDTH(DW), .KSIZE(3), .CHANNELS(CH)) ua (.clk(clk), .rst(rst_a), .bus(ifa));
  renkon_pool_maxn #(.DWIDTH(DW), .KSIZE(2), .CHANNELS(CH)) ub (.clk(clk), .rst(rst_b), .bus(ifb));

  typedef struct {int cyc; logic [W-1:0] data;} ev_t;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [W-1:0] winq[$];
  logic       m_relu;

  always @(posedge clk) cyc <= cyc + 1;

  // record every result pulse of the KSIZE=3 instance with its cycle
  always @(posedge clk) begin
    ev_t o;
    #1;
    if (ifa.out_valid === 1'b1) begin
      o.cyc = cyc; o.data = ifa.out_data;
      obs_q.push_back(o);
    end
  end

  // reference: per-lane signed max over all collected elements, then clamp
  function automatic logic [W-1:0] window_result();
    logic [W-1:0] r;
    logic signed [DW-1:0] t;
    int m, v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      t = winq[0][c*DW +: DW];
      m = t;
      for (int i = 1; i < winq.size(); i++) begin
        t = winq[i][c*DW +: DW];
        v = t;
        if (v > m) m = v;
      end
      if (m_relu && m < 0) m = 0;
      r[c*DW +: DW] = m[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_vec(input bit corners);
    logic [W-1:0] v;
    logic [31:0] t;
    for (int c = 0; c < CH; c++) begin
      t = $urandom;
      if (corners && t[31:30] == 2'b00) v[c*DW +: DW] = 16'h8000;
      else if (corners && t[31:30] == 2'b01) v[c*DW +: DW] = 16'h7FFF;
      else v[c*DW +: DW] = t[DW-1:0];
    end
    return v;
  endfunction

  task automatic feed(input logic [W-1:0] d, input logic relu, input logic clr);
    ev_t e;
    @(negedge clk);
    ifa.in_valid = 1'b1; ifa.in_data = d; ifa.relu_en = relu; ifa.clear = clr;
    if (clr) winq.delete();
    else begin
      if (winq.size() == 0) m_relu = relu;
      winq.push_back(d);
      if (winq.size() == KK) begin
        e.cyc = cyc + 1; e.data = window_result();
        exp_q.push_back(e);
        winq.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifa.in_valid = 1'b0; ifa.clear = 1'b0;
      ifa.in_data = rnd_vec(0); ifa.relu_en = 1'($urandom);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    ifa.in_valid = 1'b0; ifa.clear = 1'b1;
    winq.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld_a got %b want 0", ifa.out_valid); end
    checks++; if (ifa.out_data !== '0) begin errors++; $display("FAIL reset_data_a got %h want 0", ifa.out_data); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b want 0", ifa.busy); end
    checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld_b got %b want 0", ifb.out_valid); end
    checks++; if (ifb.out_data !== '0) begin errors++; $display("FAIL reset_data_b got %h want 0", ifb.out_data); end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_ramp();
    logic [W-1:0] d;
    ev_t o, e;
    for (int i = 1; i <= 9; i++) begin
      d = rnd_vec(0); d[DW-1:0] = i[DW-1:0];
      feed(d, 1'b0, 1'b0);
    end
    idle(2);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL ramp_pulses got %0d want 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].data[DW-1:0] !== 16'd9) begin errors++; $display("FAIL ramp_lane0 got %h want 0009", obs_q[0].data[DW-1:0]); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.data !== e.data) begin errors++; $display("FAIL ramp_win got cyc%0d %h want cyc%0d %h", o.cyc, o.data, e.cyc, e.data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_signed_relu();
    logic [W-1:0] d;
    ev_t o, e;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 9; i++) begin
        d = rnd_vec(1);
        d[DW +: DW] = (i == 4) ? 16'hFFFD : 16'hFFFB;
        // relu_en toggles mid-window; only the first element's value counts
        feed(d, (i == 0) ? r[0] : ~r[0], 1'b0);
      end
    end
    idle(2);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL signed_pulses got %0d want 2", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].data[DW +: DW] !== 16'hFFFD) begin errors++; $display("FAIL signed_lane1 got %h want fffd", obs_q[0].data[DW +: DW]); end
      checks++; if (obs_q[1].data[DW +: DW] !== 16'h0000) begin errors++; $display("FAIL relu_lane1 got %h want 0000", obs_q[1].data[DW +: DW]); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.data !== e.data) begin errors++; $display("FAIL signed_win got cyc%0d %h want cyc%0d %h", o.cyc, o.data, e.cyc, e.data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    ev_t o, e;
    for (int i = 0; i < 4; i++) feed(rnd_vec(1), 1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      idle(1);
      checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b want 1", ifa.busy); end
    end
    for (int i = 0; i < 5; i++) feed(rnd_vec(1), 1'b0, 1'b0);
    idle(3);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL stall_pulses got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.data !== e.data) begin errors++; $display("FAIL stall_win got cyc%0d %h want cyc%0d %h", o.cyc, o.data, e.cyc, e.data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t o, e;
    for (int i = 0; i < 18; i++) feed(rnd_vec(1), 1'($urandom), 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", obs_q.size()); end
    else begin
      checks++; if (obs_q[1].cyc - obs_q[0].cyc != 9) begin errors++; $display("FAIL b2b_spacing got %0d want 9", obs_q[1].cyc - obs_q[0].cyc); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.data !== e.data) begin errors++; $display("FAIL b2b_win got cyc%0d %h want cyc%0d %h", o.cyc, o.data, e.cyc, e.data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear();
    logic [W-1:0] big;
    ev_t o, e;
    big = {CH{16'h7000}};
    for (int i = 0; i < 5; i++) feed(big, 1'b0, 1'b0);
    do_clear();
    idle(1);
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b want 0", ifa.busy); end
    // clear together with an element drops that element too
    feed(big, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) feed({CH{16'd2}}, 1'b0, 1'b0);
    // clear on the final element of a window: no result at all
    for (int i = 0; i < 8; i++) feed(big, 1'b0, 1'b0);
    feed(big, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL clear_pulses got %0d want 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].data !== {CH{16'd2}}) begin errors++; $display("FAIL clear_leak got %h want all 0002", obs_q[0].data); end
    end
    checks++; if (ifa.out_data !== {CH{16'd2}}) begin errors++; $display("FAIL clear_hold got %h want all 0002", ifa.out_data); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.data !== e.data) begin errors++; $display("FAIL clear_win got cyc%0d %h want cyc%0d %h", o.cyc, o.data, e.cyc, e.data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_rst_mid();
    ev_t o, e;
    for (int i = 0; i < 7; i++) feed(rnd_vec(1), 1'b0, 1'b0);
    @(negedge clk);
    rst_a = 1'b1; ifa.in_valid = 1'b1; ifa.clear = 1'b0;
    winq.delete();
    @(posedge clk); #1;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_vld got %b want 0", ifa.out_valid); end
    checks++; if (ifa.out_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", ifa.out_data); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", ifa.busy); end
    @(negedge clk);
    rst_a = 1'b0; ifa.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) feed(rnd_vec(1), 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL rst_pulses got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.data !== e.data) begin errors++; $display("FAIL rst_win got cyc%0d %h want cyc%0d %h", o.cyc, o.data, e.cyc, e.data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_k2();
    logic [W-1:0] d, m;
    logic signed [DW-1:0] a, b;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ifb.in_valid = 1'b1; ifb.in_data = rnd_vec(1);
    end
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0; ifb.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = rnd_vec(1);
      ifb.in_valid = 1'b1; ifb.in_data = d;
      for (int c = 0; c < CH; c++) begin
        a = m[c*DW +: DW]; b = d[c*DW +: DW];
        if (i == 0 || b > a) m[c*DW +: DW] = b;
      end
      @(posedge clk); #1;
      checks++;
      if (ifb.out_valid !== (i == 3)) begin errors++; $display("FAIL k2_vld%0d got %b want %b", i, ifb.out_valid, (i == 3)); end
    end
    checks++; if (ifb.out_data !== m) begin errors++; $display("FAIL k2_data got %h want %h", ifb.out_data, m); end
    @(negedge clk); ifb.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL k2_pulse got %b want 0", ifb.out_valid); end
  endtask

  task automatic test_random();
    ev_t o, e;
    int op;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 5)      feed(rnd_vec(0), 1'($urandom), 1'b0);
      else if (op == 6) idle(1);
      else if (op == 7) do_clear();
      else if (op == 8) feed(rnd_vec(1), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      else              feed(rnd_vec(1), 1'($urandom), 1'b0);
      @(posedge clk); #2;
      checks++;
      if (ifa.busy !== (winq.size() > 0)) begin errors++; $display("FAIL rand_busy got %b want %b", ifa.busy, (winq.size() > 0)); end
    end
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_pulses got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o.cyc !== e.cyc || o.data !== e.data) begin errors++; $display("FAIL rand_win got cyc%0d %h want cyc%0d %h", o.cyc, o.data, e.cyc, e.data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.clear = 1'b0; ifa.relu_en = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.clear = 1'b0; ifb.relu_en = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0;
    test_reset();
    test_ramp();
    test_signed_relu();
    test_stall();
    test_back_to_back();
    test_clear();
    test_rst_mid();
    test_k2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
